// File: rtl/br_rs_pkg.sv
// rtl/br_rs_pkg.sv - shared core types: register-file sizing, branch opcodes, branch unit issue payload
package br_rs_pkg;

    localparam int PRF_IDX_W = 6;
    localparam int ROB_IDX_W = 6;

    typedef enum logic [3:0] {
        BR_BEQ,
        BR_BNE,
        BR_BLT,
        BR_BGE,
        BR_BLTU,
        BR_BGEU,
        BR_JAL,
        BR_JALR,
        BR_AUIPC
    } br_op_e;

    typedef struct packed {
        br_op_e                op;
        logic [31:0]           pc;
        logic [31:0]           imm;
        logic [ROB_IDX_W-1:0]  rob_id;
        logic [4:0]            rd_arch;
        logic [PRF_IDX_W-1:0]  rd_phy;
        logic [31:0]           rs1_value;
        logic [31:0]           rs2_value;
        logic                  predict_taken;
        logic [31:0]           predict_target;
    } fu_br_reg_t;

endpackage

// File: rtl/int_rs_types.sv
// rtl/int_rs_types.sv - reservation-station dispatch and entry types
package int_rs_types;

    import br_rs_pkg::*;

    localparam int BR_RS_DEPTH = 4;

    typedef struct packed {
        br_op_e                op;
        logic [31:0]           pc;
        logic [31:0]           imm;
        logic [ROB_IDX_W-1:0]  rob_id;
        logic [4:0]            rd_arch;
        logic [PRF_IDX_W-1:0]  rd_phy;
        logic [PRF_IDX_W-1:0]  rs1_phy;
        logic [PRF_IDX_W-1:0]  rs2_phy;
        logic                  rs1_ready;
        logic                  rs2_ready;
        logic [31:0]           rs1_value;
        logic [31:0]           rs2_value;
        logic                  predict_taken;
        logic [31:0]           predict_target;
    } br_dispatch_t;

    typedef struct packed {
        logic         valid;
        br_dispatch_t uop;
    } br_rs_entry_t;

endpackage

// File: rtl/br_rs_wakeup.sv
// rtl/br_rs_wakeup.sv - one operand's CDB tag compare and value capture mux
module br_rs_wakeup
    import br_rs_pkg::*;
#(
    parameter int CDB_PORTS = 4
) (
    input  logic                                 rdy_in,
    input  logic [PRF_IDX_W-1:0]                 tag,
    input  logic [31:0]                          value_in,
    input  logic [CDB_PORTS-1:0]                 cdb_valid,
    input  logic [CDB_PORTS-1:0][PRF_IDX_W-1:0]  cdb_rd_phy,
    input  logic [CDB_PORTS-1:0][31:0]           cdb_rd_value,
    output logic                                 rdy_out,
    output logic [31:0]                          value_out
);

    // Physical register 0 is hardwired zero; lowest matching port wins on duplicates.
    always_comb begin
        rdy_out   = rdy_in;
        value_out = value_in;
        if (tag == '0) begin
            rdy_out   = 1'b1;
            value_out = '0;
        end else if (!rdy_in) begin
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (cdb_valid[p] && cdb_rd_phy[p] == tag) begin
                    rdy_out   = 1'b1;
                    value_out = cdb_rd_value[p];
                end
            end
        end
    end

endmodule

// File: rtl/br_rs.sv
// rtl/br_rs.sv - branch reservation station: collapsing age queue with CDB operand wakeup
module br_rs
    import br_rs_pkg::*;
#(
    parameter int BR_RS_DEPTH = int_rs_types::BR_RS_DEPTH,
    parameter int CDB_PORTS   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 backend_flush,
    input  logic                                 dispatch_valid,
    output logic                                 dispatch_ready,
    input  int_rs_types::br_dispatch_t           dispatch_uop,
    input  logic [CDB_PORTS-1:0]                 cdb_valid,
    input  logic [CDB_PORTS-1:0][PRF_IDX_W-1:0]  cdb_rd_phy,
    input  logic [CDB_PORTS-1:0][31:0]           cdb_rd_value,
    output logic                                 br_rs_valid,
    input  logic                                 fu_br_ready,
    output fu_br_reg_t                           fu_br_reg_in
);

    localparam int CNT_W = $clog2(BR_RS_DEPTH + 1);
    localparam int IDX_W = $clog2(BR_RS_DEPTH);

    int_rs_types::br_rs_entry_t ent_q   [BR_RS_DEPTH];
    int_rs_types::br_rs_entry_t ent_wk  [BR_RS_DEPTH+1];
    int_rs_types::br_rs_entry_t ent_nxt [BR_RS_DEPTH];
    int_rs_types::br_dispatch_t disp_n, disp_wk, sel_uop;

    logic [CNT_W-1:0]       count_q, count_nxt, wr_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_found, issue, accept;
    logic [BR_RS_DEPTH-1:0] rs1_rdy_wk, rs2_rdy_wk;
    logic [31:0]            rs1_val_wk [BR_RS_DEPTH];
    logic [31:0]            rs2_val_wk [BR_RS_DEPTH];
    logic                   disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0]            disp_rs1_val, disp_rs2_val;

    // Operands the opcode never reads are marked ready so they cannot stall issue.
    always_comb begin
        disp_n = dispatch_uop;
        if (dispatch_uop.op inside {BR_JAL, BR_AUIPC})
            disp_n.rs1_ready = 1'b1;
        if (dispatch_uop.op inside {BR_JAL, BR_JALR, BR_AUIPC})
            disp_n.rs2_ready = 1'b1;
    end

    br_rs_wakeup #(.CDB_PORTS(CDB_PORTS)) u_disp_rs1 (
        .rdy_in(disp_n.rs1_ready), .tag(disp_n.rs1_phy), .value_in(disp_n.rs1_value),
        .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value),
        .rdy_out(disp_rs1_rdy), .value_out(disp_rs1_val)
    );
    br_rs_wakeup #(.CDB_PORTS(CDB_PORTS)) u_disp_rs2 (
        .rdy_in(disp_n.rs2_ready), .tag(disp_n.rs2_phy), .value_in(disp_n.rs2_value),
        .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value),
        .rdy_out(disp_rs2_rdy), .value_out(disp_rs2_val)
    );

    for (genvar g = 0; g < BR_RS_DEPTH; g++) begin : g_wk
        br_rs_wakeup #(.CDB_PORTS(CDB_PORTS)) u_rs1 (
            .rdy_in(ent_q[g].uop.rs1_ready), .tag(ent_q[g].uop.rs1_phy),
            .value_in(ent_q[g].uop.rs1_value),
            .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value),
            .rdy_out(rs1_rdy_wk[g]), .value_out(rs1_val_wk[g])
        );
        br_rs_wakeup #(.CDB_PORTS(CDB_PORTS)) u_rs2 (
            .rdy_in(ent_q[g].uop.rs2_ready), .tag(ent_q[g].uop.rs2_phy),
            .value_in(ent_q[g].uop.rs2_value),
            .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value),
            .rdy_out(rs2_rdy_wk[g]), .value_out(rs2_val_wk[g])
        );
    end

    // The extra slot past the end is an empty entry shifted into the top on issue.
    always_comb begin
        disp_wk           = disp_n;
        disp_wk.rs1_ready = disp_rs1_rdy;
        disp_wk.rs1_value = disp_rs1_val;
        disp_wk.rs2_ready = disp_rs2_rdy;
        disp_wk.rs2_value = disp_rs2_val;
        for (int i = 0; i < BR_RS_DEPTH; i++) begin
            ent_wk[i]               = ent_q[i];
            ent_wk[i].uop.rs1_ready = rs1_rdy_wk[i];
            ent_wk[i].uop.rs1_value = rs1_val_wk[i];
            ent_wk[i].uop.rs2_ready = rs2_rdy_wk[i];
            ent_wk[i].uop.rs2_value = rs2_val_wk[i];
        end
        ent_wk[BR_RS_DEPTH] = '0;
    end

    // Eligibility uses stored ready flags only, so a same-cycle wakeup issues next cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = BR_RS_DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].uop.rs1_ready && ent_q[i].uop.rs2_ready) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_uop                     = ent_q[sel_idx].uop;
        fu_br_reg_in.op             = sel_uop.op;
        fu_br_reg_in.pc             = sel_uop.pc;
        fu_br_reg_in.imm            = sel_uop.imm;
        fu_br_reg_in.rob_id         = sel_uop.rob_id;
        fu_br_reg_in.rd_arch        = sel_uop.rd_arch;
        fu_br_reg_in.rd_phy         = sel_uop.rd_phy;
        fu_br_reg_in.rs1_value      = sel_uop.rs1_value;
        fu_br_reg_in.rs2_value      = sel_uop.rs2_value;
        fu_br_reg_in.predict_taken  = sel_uop.predict_taken;
        fu_br_reg_in.predict_target = sel_uop.predict_target;
    end

    assign dispatch_ready = count_q < CNT_W'(BR_RS_DEPTH);
    assign br_rs_valid    = sel_found && !backend_flush;
    assign issue          = br_rs_valid && fu_br_ready;
    assign accept         = dispatch_valid && dispatch_ready && !backend_flush;
    assign wr_idx         = count_q - CNT_W'(issue);
    assign count_nxt      = backend_flush ? '0 : count_q - CNT_W'(issue) + CNT_W'(accept);

    always_comb begin
        for (int i = 0; i < BR_RS_DEPTH; i++) begin
            if (issue && i >= int'(sel_idx))
                ent_nxt[i] = ent_wk[i+1];
            else
                ent_nxt[i] = ent_wk[i];
            if (accept && i == int'(wr_idx)) begin
                ent_nxt[i].valid = 1'b1;
                ent_nxt[i].uop   = disp_wk;
            end
            if (backend_flush)
                ent_nxt[i].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < BR_RS_DEPTH; i++)
                ent_q[i] <= '0;
        end else begin
            count_q <= count_nxt;
            for (int i = 0; i < BR_RS_DEPTH; i++)
                ent_q[i] <= ent_nxt[i];
        end
    end

endmodule

// File: tb/tb_br_rs.sv
// tb/tb_br_rs.sv - directed self-checking bench for br_rs
module tb_br_rs;
    import br_rs_pkg::*;
    import int_rs_types::*;

    localparam int DEPTH = 4;
    localparam int PORTS = 4;

    logic                             clk = 1'b0;
    logic                             rst_n;
    logic                             backend_flush;
    logic                             dispatch_valid;
    logic                             dispatch_ready;
    br_dispatch_t                     dispatch_uop;
    logic [PORTS-1:0]                 cdb_valid;
    logic [PORTS-1:0][PRF_IDX_W-1:0]  cdb_rd_phy;
    logic [PORTS-1:0][31:0]           cdb_rd_value;
    logic                             br_rs_valid;
    logic                             fu_br_ready;
    fu_br_reg_t                       fu_br_reg_in;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    br_rs #(.BR_RS_DEPTH(DEPTH), .CDB_PORTS(PORTS)) dut (
        .clk(clk), .rst_n(rst_n), .backend_flush(backend_flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_uop(dispatch_uop), .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy),
        .cdb_rd_value(cdb_rd_value), .br_rs_valid(br_rs_valid),
        .fu_br_ready(fu_br_ready), .fu_br_reg_in(fu_br_reg_in)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        backend_flush  = 1'b0;
        cdb_valid      = '0;
    endtask

    task automatic disp(input br_dispatch_t u);
        dispatch_valid = 1'b1;
        dispatch_uop   = u;
    endtask

    task automatic cdb(input int p, input int tag, input logic [31:0] v);
        cdb_valid[p]    = 1'b1;
        cdb_rd_phy[p]   = PRF_IDX_W'(tag);
        cdb_rd_value[p] = v;
    endtask

    function automatic br_dispatch_t mk(input br_op_e op, input int rob,
                                        input int t1, input bit r1, input logic [31:0] v1,
                                        input int t2, input bit r2, input logic [31:0] v2);
        br_dispatch_t u;
        u           = '0;
        u.op        = op;
        u.pc        = 32'h1000 + 32'(rob) * 4;
        u.rob_id    = ROB_IDX_W'(rob);
        u.rs1_phy   = PRF_IDX_W'(t1);
        u.rs1_ready = r1;
        u.rs1_value = v1;
        u.rs2_phy   = PRF_IDX_W'(t2);
        u.rs2_ready = r2;
        u.rs2_value = v2;
        return u;
    endfunction

    initial begin
        rst_n        = 1'b0;
        fu_br_ready  = 1'b0;
        dispatch_uop = '0;
        cdb_rd_phy   = '0;
        cdb_rd_value = '0;
        idle();
        tick();
        #1;
        check("reset_valid", br_rs_valid, 0);
        check("reset_ready", dispatch_ready, 1);
        tick();
        rst_n = 1'b1;

        // BEQ waits on tag 12, woken by cdb port 2
        disp(mk(BR_BEQ, 1, 3, 1, 5, 12, 0, 0));
        #1;
        check("t1_dispatch_ready", dispatch_ready, 1);
        tick(); idle(); cdb(2, 12, 5); #1;
        check("t1_wait_valid", br_rs_valid, 0);
        tick(); idle(); #1;
        check("t1_wake_valid", br_rs_valid, 1);
        check("t1_rs1_value", fu_br_reg_in.rs1_value, 5);
        check("t1_rs2_value", fu_br_reg_in.rs2_value, 5);
        check("t1_rob", fu_br_reg_in.rob_id, 1);
        tick(); #1;
        check("t1_hold_valid", br_rs_valid, 1);
        check("t1_hold_rob", fu_br_reg_in.rob_id, 1);
        fu_br_ready = 1'b1;
        tick(); fu_br_ready = 1'b0; #1;
        check("t1_empty", br_rs_valid, 0);

        // fill to capacity, including JAL/AUIPC whose operand tags are never broadcast
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: disp(mk(BR_BEQ,   0, 0, 1, 0, 0, 1, 0));
                1: disp(mk(BR_BGEU,  1, 1, 1, 3, 2, 1, 4));
                2: disp(mk(BR_JAL,   2, 30, 0, 0, 31, 0, 0));
                default: disp(mk(BR_AUIPC, 3, 32, 0, 0, 33, 0, 0));
            endcase
            tick();
        end
        idle();
        disp(mk(BR_BNE, 9, 0, 1, 0, 0, 1, 0));
        fu_br_ready = 1'b1;
        #1;
        check("t2_full_ready", dispatch_ready, 0);
        check("t2_full_valid", br_rs_valid, 1);
        check("t2_order_0", fu_br_reg_in.rob_id, 0);
        tick(); idle();
        for (int k = 1; k < 4; k++) begin
            #1;
            check("t2_valid", br_rs_valid, 1);
            check("t2_order", fu_br_reg_in.rob_id, k);
            tick();
        end
        #1;
        check("t2_drained", br_rs_valid, 0);

        // JALR dispatched in the same cycle its rs1 tag is broadcast
        disp(mk(BR_JALR, 5, 7, 0, 0, 9, 0, 0));
        cdb(0, 7, 32'h40);
        #1;
        check("t3_same_cycle_valid", br_rs_valid, 0);
        tick(); idle(); #1;
        check("t3_valid", br_rs_valid, 1);
        check("t3_rob", fu_br_reg_in.rob_id, 5);
        check("t3_rs1_value", fu_br_reg_in.rs1_value, 32'h40);
        tick(); #1;
        check("t3_empty", br_rs_valid, 0);
        fu_br_ready = 1'b0;

        // younger ready entry issues while older and youngest wake; youngest compacts
        disp(mk(BR_BNE, 10, 20, 0, 0, 0, 0, 0)); tick();
        disp(mk(BR_BLT, 11, 4, 1, 1, 5, 1, 2)); tick();
        disp(mk(BR_BGE, 12, 21, 0, 0, 0, 0, 0)); tick();
        idle();
        fu_br_ready = 1'b1;
        cdb(3, 20, 32'h77);
        cdb(1, 21, 32'h88);
        #1;
        check("t4_first_valid", br_rs_valid, 1);
        check("t4_first_rob", fu_br_reg_in.rob_id, 11);
        tick(); idle(); #1;
        check("t4_second_rob", fu_br_reg_in.rob_id, 10);
        check("t4_second_rs1", fu_br_reg_in.rs1_value, 32'h77);
        check("t4_second_rs2", fu_br_reg_in.rs2_value, 0);
        tick(); #1;
        check("t4_third_rob", fu_br_reg_in.rob_id, 12);
        check("t4_third_rs1", fu_br_reg_in.rs1_value, 32'h88);
        tick(); #1;
        check("t4_empty", br_rs_valid, 0);
        fu_br_ready = 1'b0;

        // flush with three held entries and a concurrent dispatch
        for (int k = 0; k < 3; k++) begin
            disp(mk(BR_BEQ, 20 + k, 0, 1, 0, 0, 1, 0));
            tick();
        end
        idle(); #1;
        check("t5_pre_valid", br_rs_valid, 1);
        backend_flush = 1'b1;
        fu_br_ready   = 1'b1;
        disp(mk(BR_BEQ, 30, 0, 1, 0, 0, 1, 0));
        #1;
        check("t5_flush_valid", br_rs_valid, 0);
        tick(); idle(); #1;
        check("t5_after_valid", br_rs_valid, 0);
        check("t5_after_ready", dispatch_ready, 1);
        tick(); #1;
        check("t5_never_issued", br_rs_valid, 0);
        fu_br_ready = 1'b0;

        // asynchronous reset mid-operation
        disp(mk(BR_BEQ, 40, 0, 1, 0, 0, 1, 0)); tick();
        disp(mk(BR_BEQ, 41, 0, 1, 0, 0, 1, 0)); tick();
        idle(); #1;
        check("t6_pre_valid", br_rs_valid, 1);
        check("t6_pre_rob", fu_br_reg_in.rob_id, 40);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", br_rs_valid, 0);
        check("t6_rst_ready", dispatch_ready, 1);
        tick();
        rst_n = 1'b1;
        #1;
        check("t6_post_valid", br_rs_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/br_rs.md
BR_RS -- requirements
Module: br_rs

Interface
REQ-001 SHALL have parameter BR_RS_DEPTH, default 4: number of reservation entries, at least 2.
REQ-002 SHALL have parameter CDB_PORTS, default 4: number of result-broadcast ports snooped for operand wakeup.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port backend_flush, input, 1 bit: squashes all held branch uops.
REQ-006 SHALL have port dispatch_valid, input, 1 bit: rename/dispatch offers one branch-class uop.
REQ-007 SHALL have port dispatch_ready, output, 1 bit: the block can accept that uop.
REQ-008 SHALL have port dispatch_uop, input, br_dispatch_t: opcode, pc, imm, rob_id, rd_arch, rd_phy, rs1/rs2 phy, rs1/rs2 ready flags and values, predict_taken, predict_target.
REQ-009 SHALL have port cdb_valid, input, [CDB_PORTS] bits: per-port broadcast valid.
REQ-010 SHALL have port cdb_rd_phy, input, [CDB_PORTS] x PRF index width: broadcast destination tag.
REQ-011 SHALL have port cdb_rd_value, input, [CDB_PORTS] x 32 bits: broadcast result value.
REQ-012 SHALL have port br_rs_valid, output, 1 bit: issue request to the branch functional unit.
REQ-013 SHALL have port fu_br_ready, input, 1 bit: the branch functional unit accepts the issued uop.
REQ-014 SHALL have port fu_br_reg_in, output, fu_br_reg_t: issued uop with rs1_value and rs2_value resolved.

Function
REQ-015 SHALL keep entries as a collapsing age queue: index 0 is the oldest, and valid entries are contiguous from index 0.
REQ-016 SHALL drive dispatch_ready = (count < BR_RS_DEPTH), with no credit for a same-cycle issue, so a full queue deasserts ready even when an issue is occurring.
REQ-017 SHALL write an accepted uop (dispatch_valid && dispatch_ready && !backend_flush) at index count minus issued, where issued is 1 if an issue occurs in the same cycle and 0 otherwise.
REQ-018 SHALL, for an operand whose ready flag is clear, compare its tag against every valid cdb port each cycle, and on a match capture cdb_rd_value and set the ready flag at the next edge.
REQ-019 SHALL apply the REQ-018 wakeup compare to dispatch_uop in its acceptance cycle, so a broadcast coinciding with dispatch is not lost.
REQ-020 SHALL ignore rs2 for BR_JAL, BR_JALR and BR_AUIPC, and SHALL ignore rs1 for BR_JAL and BR_AUIPC, treating the ignored operands as ready.
REQ-021 SHALL make an entry issue-eligible only when both of its operands are ready in stored state; an entry woken this cycle SHALL issue at the earliest in the next cycle.
REQ-022 SHALL select the lowest-index eligible entry and drive br_rs_valid combinationally from stored state, with fu_br_reg_in equal to that entry's contents.
REQ-023 SHALL treat the selected entry as issued when br_rs_valid && fu_br_ready, remove it, and shift all younger entries down by one at the same edge.
REQ-024 SHALL hold br_rs_valid and fu_br_reg_in stable while fu_br_ready is low, holding the selection unless an older entry becomes eligible.
REQ-025 SHALL force br_rs_valid to 0 during a backend_flush cycle, drop any dispatch offered in that cycle, and leave count at 0 at the next edge.
REQ-026 SHALL apply a wakeup to a shifting entry at its new index, so no broadcast is lost on compaction.
REQ-027 SHALL treat a tag of 0 as always ready with value 0.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously clear all entry valid bits and count, drive br_rs_valid to 0 and dispatch_ready to 1, and ignore all other inputs.
REQ-029 SHALL leave the fu_br_reg_in payload don't-care while br_rs_valid is 0.

Structure
REQ-030 SHALL place br_dispatch_t, br_rs_entry_t and BR_RS_DEPTH in int_rs_types, and SHALL take fu_br_reg_t and the BR_* opcodes from the existing shared packages.
REQ-031 SHALL use one sub-module, br_rs_wakeup, holding the per-operand CDB tag compare and value mux, instantiated once per entry operand and for the dispatch bypass.

Verification
REQ-032 SHALL cover: dispatch a BEQ with rs1 ready (5) and rs2 tag 12 not ready; cdb port 2 broadcasts tag 12 with value 5 -> br_rs_valid rises exactly one cycle later with rs1_value=5, rs2_value=5.
REQ-033 SHALL cover: fill 4 entries, all ready, with fu_br_ready=1 -> issue order is rob_id 0,1,2,3 and dispatch_ready is 0 during the full cycle.
REQ-034 SHALL cover: cdb broadcasts tag 7 with value 0x40 in the cycle a JALR with rs1 tag 7 dispatches -> the entry issues the next cycle with rs1_value=0x40.
REQ-035 SHALL cover: entry 0 waiting, entry 1 ready, then entry 0 wakes while entry 1 is issuing -> entry 1 issues first, and entry 0 compacts to index 0 with the captured value.
REQ-036 SHALL cover: 3 entries valid with backend_flush asserted alongside a dispatch -> br_rs_valid is 0 that cycle, count is 0 next cycle, and the offered uop never issues.
REQ-037 SHALL cover: rst_n pulsed low asynchronously mid-operation -> br_rs_valid drops immediately and dispatch_ready reads 1.
